// File: rtl/tcb_pkg.sv
// Shared TCB helpers: select-width rule and one-hot to index conversion.
package tcb_pkg;

    // Select width for an n-way port array, SW = $clog2(n).
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the set bit in a one-hot vector (up to 32 ports).
    function automatic int unsigned onehot_to_index(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tcb_arb_pick.sv
// Rotating priority encoder: first set request at or after 'start' (mod PN) wins.
module tcb_arb_pick
    import tcb_pkg::*;
#(
    parameter int unsigned PN = 2,
    parameter int unsigned SW = sel_width(PN)
) (
    input  logic [PN-1:0] req,
    input  logic [SW-1:0] start,
    output logic [PN-1:0] gnt
);

    logic [SW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < PN; k++) begin
            idx = SW'((32'(start) + k) % PN);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcb_arb.sv
// TCB arbiter merging PN managers onto one subordinate port.
// Define TCB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed lowest-index priority.
module tcb_arb
    import tcb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned PN = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    // subordinate ports, managers connect here
    input  logic [PN-1:0]             s_vld,
    input  logic [PN-1:0]             s_wen,
    input  logic [PN-1:0][DW/8-1:0]   s_ben,
    input  logic [PN-1:0][AW-1:0]     s_adr,
    input  logic [PN-1:0][DW-1:0]     s_wdt,
    output logic [PN-1:0]             s_rdy,
    output logic [PN-1:0][DW-1:0]     s_rdt,
    output logic [PN-1:0]             s_err,
    // manager port toward the shared subordinate
    output logic                      m_vld,
    output logic                      m_wen,
    output logic [DW/8-1:0]           m_ben,
    output logic [AW-1:0]             m_adr,
    output logic [DW-1:0]             m_wdt,
    input  logic                      m_rdy,
    input  logic [DW-1:0]             m_rdt,
    input  logic                      m_err
);

    localparam int unsigned SW = sel_width(PN);

    logic [PN-1:0] pol_gnt;
    logic [PN-1:0] gnt;
    logic [PN-1:0] hld_gnt;
    logic          hld;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] rsp_sel;
    logic          rsp_vld;
    logic [SW-1:0] start;
    logic          xfer;

    assign m_vld   = |s_vld;
    assign xfer    = m_vld & m_rdy;
    assign gnt     = hld ? hld_gnt : pol_gnt;
    assign gnt_idx = SW'(onehot_to_index(32'(gnt)));

`ifdef TCB_ARB_ROUND_ROBIN_EN
    logic [SW-1:0] ptr;

    assign start = (ptr == SW'(PN - 1)) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SW'(PN - 1);
        end else if (xfer) begin
            ptr <= gnt_idx;
        end
    end
`else
    assign start = '0;
`endif

    tcb_arb_pick #(
        .PN (PN),
        .SW (SW)
    ) u_pick (
        .req   (s_vld),
        .start (start),
        .gnt   (pol_gnt)
    );

    // Freeze the grant while the subordinate stalls so the request stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            hld     <= 1'b0;
            hld_gnt <= '0;
        end else if (m_vld && !m_rdy) begin
            hld     <= 1'b1;
            hld_gnt <= gnt;
        end else if (xfer) begin
            hld     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld <= 1'b0;
            rsp_sel <= '0;
        end else begin
            rsp_vld <= xfer;
            if (xfer) rsp_sel <= gnt_idx;
        end
    end

    always_comb begin
        m_wen = 'x;
        m_ben = 'x;
        m_adr = 'x;
        m_wdt = 'x;
        for (int unsigned i = 0; i < PN; i++) begin
            if (gnt[i]) begin
                m_wen = s_wen[i];
                m_ben = s_ben[i];
                m_adr = s_adr[i];
                m_wdt = s_wdt[i];
            end
        end
    end

    always_comb begin
        s_rdy = {PN{m_rdy}} & gnt;
        for (int unsigned i = 0; i < PN; i++) begin
            s_rdt[i] = m_rdt;
            s_err[i] = m_err & rsp_vld & (rsp_sel == SW'(i));
        end
    end

    // A held request must stay asserted until accepted.
    a_hold_stable : assert property (@(posedge clk) disable iff (rst) hld |-> |(s_vld & hld_gnt));

endmodule

// File: tb/tb_tcb_arb.sv
// Self-checking bench for tcb_arb: vector table, hand sequences and randomized model check.
module tb_tcb_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned PN = 4;
    localparam int unsigned BW = DW / 8;
`ifdef TCB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [PN-1:0]           s_vld, s_wen, s_rdy, s_err;
    logic [PN-1:0][BW-1:0]   s_ben;
    logic [PN-1:0][AW-1:0]   s_adr;
    logic [PN-1:0][DW-1:0]   s_wdt, s_rdt;
    logic                    m_vld, m_wen, m_rdy, m_err;
    logic [BW-1:0]           m_ben;
    logic [AW-1:0]           m_adr;
    logic [DW-1:0]           m_wdt, m_rdt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcb_arb #(
        .AW (AW),
        .DW (DW),
        .PN (PN)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_vld (s_vld),
        .s_wen (s_wen),
        .s_ben (s_ben),
        .s_adr (s_adr),
        .s_wdt (s_wdt),
        .s_rdy (s_rdy),
        .s_rdt (s_rdt),
        .s_err (s_err),
        .m_vld (m_vld),
        .m_wen (m_wen),
        .m_ben (m_ben),
        .m_adr (m_adr),
        .m_wdt (m_wdt),
        .m_rdy (m_rdy),
        .m_rdt (m_rdt),
        .m_err (m_err)
    );

    typedef struct {
        logic [PN-1:0] vld;
        logic          rdy;
        logic          merr;
        logic          mvld;
        logic [PN-1:0] rdy_o;
        logic [PN-1:0] err_o;
        logic [AW-1:0] adr;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic [PN-1:0] vld, input logic rdy, input logic merr);
        s_vld = vld;
        m_rdy = rdy;
        m_err = merr;
    endtask

    task automatic default_fields();
        for (int i = 0; i < PN; i++) begin
            s_adr[i] = 32'h10 * (i + 1);
            s_wen[i] = 1'b0;
            s_ben[i] = '1;
            s_wdt[i] = 32'(i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // reference model state for the randomized phase
    int            held, last, rsp_port, g;
    bit            rsp_vld_m;
    bit [PN-1:0]   pend;
    logic [PN-1:0] exp_rdy, exp_err;

    initial begin
        tbl[0]  = '{4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 32'h10};
        tbl[1]  = '{4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 32'h10};
        tbl[2]  = '{4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 32'h10};
        tbl[3]  = '{4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 32'h10};
        tbl[4]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 32'h20};
        tbl[5]  = '{4'b0010, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0010, 32'h20};
        tbl[6]  = '{4'b0010, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 32'h20};
        tbl[7]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h20};
        tbl[8]  = '{4'b0011, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h20};
        tbl[9]  = '{4'b0011, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 32'h20};
        tbl[10] = '{4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 32'h10};
        tbl[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 32'h0};
        tbl[12] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0};
`ifdef TCB_ARB_ROUND_ROBIN_EN
        // round-robin alternates between the two simultaneous readers
        tbl[1].rdy_o = 4'b0010;
        tbl[1].adr   = 32'h20;
        tbl[3].rdy_o = 4'b0010;
        tbl[3].adr   = 32'h20;
`endif

        default_fields();
        m_rdt = '0;

        // reset with idle inputs
        rst = 1'b1;
        drive('0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("reset_m_vld", m_vld, 1'b0);
            chk("reset_s_rdy", s_rdy, '0);
            chk("reset_s_err", s_err, '0);
            tick();
        end
        rst = 1'b0;

        // vector table: simultaneous reads, stall hold, error routing
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vld, tbl[i].rdy, tbl[i].merr);
            settle();
            chk($sformatf("vec%0d_s_rdy", i), s_rdy, tbl[i].rdy_o);
            chk($sformatf("vec%0d_m_vld", i), m_vld, tbl[i].mvld);
            chk($sformatf("vec%0d_s_err", i), s_err, tbl[i].err_o);
            if (tbl[i].mvld) chk($sformatf("vec%0d_m_adr", i), m_adr, tbl[i].adr);
            tick();
        end

        // fairness: all four request continuously
        do_reset();
        drive(4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("fair%0d_s_rdy", k), s_rdy, RR ? (4'b0001 << (k % 4)) : 4'b0001);
            tick();
        end

        // error routing: write from port 1, subordinate answers with err
        do_reset();
        s_wen[1] = 1'b1;
        s_adr[1] = 32'h40;
        s_wdt[1] = 32'hdead_beef;
        drive(4'b0010, 1'b1, 1'b0);
        settle();
        chk("err_req_s_rdy", s_rdy, 4'b0010);
        chk("err_req_m_adr", m_adr, 32'h40);
        chk("err_req_m_wen", m_wen, 1'b1);
        chk("err_req_m_wdt", m_wdt, 32'hdead_beef);
        tick();
        drive('0, 1'b1, 1'b1);
        m_rdt = 32'h1234_5678;
        settle();
        chk("err_rsp_s_err", s_err, 4'b0010);
        chk("err_rsp_rdt0", s_rdt[0], 32'h1234_5678);
        chk("err_rsp_rdt1", s_rdt[1], 32'h1234_5678);
        tick();
        settle();
        chk("err_after_s_err", s_err, 4'b0000);
        tick();
        default_fields();

        // reset during a held request
        do_reset();
        drive(4'b0010, 1'b1, 1'b0);
        tick();
        drive(4'b0100, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(4'b1111, 1'b1, 1'b1);
        settle();
        chk("rstmid_s_rdy", s_rdy, 4'b0001);
        chk("rstmid_m_adr", m_adr, 32'h10);
        chk("rstmid_s_err", s_err, 4'b0000);
        tick();
        // reset on a transfer cycle drops the pending response
        rst = 1'b1;
        drive(4'b0001, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        drive('0, 1'b1, 1'b1);
        settle();
        chk("rstxfer_s_err", s_err, 4'b0000);
        tick();

        // randomized traffic against the reference model
        do_reset();
        held = -1;
        last = PN - 1;
        rsp_vld_m = 1'b0;
        rsp_port = 0;
        pend = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < PN; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]  = 1'b1;
                    s_adr[i] = $urandom;
                    s_wen[i] = 1'($urandom_range(1, 0));
                    s_ben[i] = BW'($urandom);
                    s_wdt[i] = $urandom;
                end
            end
            drive(pend, $urandom_range(3, 0) != 0, 1'($urandom_range(1, 0)));
            m_rdt = $urandom;

            g = -1;
            if (held >= 0) begin
                g = held;
            end else if (RR) begin
                for (int k = 1; k <= PN; k++) begin
                    if (g < 0 && s_vld[(last + k) % PN]) g = (last + k) % PN;
                end
            end else begin
                for (int p = 0; p < PN; p++) begin
                    if (g < 0 && s_vld[p]) g = p;
                end
            end
            exp_rdy = (g >= 0 && m_rdy) ? PN'(1 << g) : '0;
            exp_err = (m_err && rsp_vld_m) ? PN'(1 << rsp_port) : '0;

            settle();
            chk("rnd_s_rdy", s_rdy, exp_rdy);
            chk("rnd_m_vld", m_vld, g >= 0);
            chk("rnd_s_err", s_err, exp_err);
            chk("rnd_s_rdt", s_rdt[cyc % PN], m_rdt);
            if (g >= 0) begin
                chk("rnd_m_adr", m_adr, s_adr[g]);
                chk("rnd_m_ctl", {m_wen, m_ben, m_wdt}, {s_wen[g], s_ben[g], s_wdt[g]});
            end

            if (g >= 0 && m_rdy) begin
                held = -1;
                last = g;
                rsp_vld_m = 1'b1;
                rsp_port = g;
            end else begin
                rsp_vld_m = 1'b0;
                if (g >= 0) held = g;
            end
            for (int i = 0; i < PN; i++) begin
                if (s_rdy[i]) pend[i] = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcb_arb.md
# tcb_arb

TCB arbiter: connects PN TCB managers to a single TCB subordinate port. It is the mirror of the TCB decoder; the decoder fans one manager out to many subordinates, and this block merges many managers onto one subordinate. It sits in front of shared memories and peripherals that more than one bus manager must reach, e.g. instruction fetch plus load/store. Request arbitration is single-cycle, and responses are routed back to the manager that owned the accepted request.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; `DW/8` byte enables
- `PN`, 2, number of manager ports, ≥2
- `clk` in 1: clock, shared by all TCB interfaces
- `rst` in 1: reset, synchronous, active-high
- `s[PN-1:0]` tcb_if.sub: subordinate ports; managers connect here
- `m` tcb_if.man: manager port; the shared subordinate connects here

## Operation
- Protocol:
  - Request signals: `vld`, `wen`, `ben`, `adr`, `wdt`.
  - A transfer occurs on a cycle with `vld & rdy`.
  - `rdy` is a request-phase signal.
  - `rdt` and `err` are valid the cycle after the transfer.
- Grant:
  - `gnt` is a one-hot signal of width PN.
  - `gnt` is computed combinationally from `s[*].vld`, using the policy below.
  - If no manager has `vld` high, `gnt = 0`.
- Request path:
  - `m.vld = |s[*].vld`.
  - `m.wen/ben/adr/wdt` are driven from the granted port; they are `'x` when there is no grant.
  - `s[i].rdy = m.rdy & gnt[i]`. Non-granted managers see `rdy = 0`.
- Hold:
  - If `m.vld & ~m.rdy`, register the current `gnt` into `hld_gnt` and set `hld = 1`.
  - While `hld = 1`, `gnt = hld_gnt` regardless of the policy, so the request is stable toward a stalled subordinate.
  - `hld` clears on the cycle `m.vld & m.rdy`.
  - Managers must keep `vld` asserted until `rdy`. A dropped held request is a protocol violation and is reported by an assertion.
- Response routing:
  - On `m.vld & m.rdy`, register `rsp_sel <= index(gnt)` and `rsp_vld <= 1`; otherwise `rsp_vld <= 0`.
  - `s[i].rdt = m.rdt` for every port (broadcast).
  - `s[i].err = m.err & rsp_vld & (rsp_sel == i)`.
- Policy, fixed priority (macro off): the lowest index with `vld` wins.
- Policy, round-robin (macro on):
  - Register `ptr` holds the index of the last port granted with a completed transfer.
  - The search starts at `ptr+1` modulo PN, so after PN-1 it wraps to 0.
  - `ptr` updates only on `m.vld & m.rdy`, never on a grant that has no transfer.
- Reset values:
  - `hld = 0`, `hld_gnt = 0`, `rsp_sel = 0`, `rsp_vld = 0`.
  - `ptr = PN-1`, so port 0 has first priority.
  - All `s[*].rdy` and `s[*].err` are 0 while the inputs are idle.
- Reset mid-transfer: held grant and pending response are dropped; no `err` is issued the next cycle.

## Timing
- Request path, `vld` to `m.vld` and `m.rdy` to `s[i].rdy`: combinational, 0 cycles.
- Response: same 1-cycle latency as the subordinate; no added latency.
- Back-to-back transfers from different managers are allowed every cycle.
- `rsp_sel` switches per transfer.
- Simultaneous requests: exactly one transfer per cycle; losers wait with `rdy = 0`.
- Round-robin fairness: a continuously requesting manager is served within PN transfers.
- Single requester: it is granted every cycle regardless of `ptr`.

## Configuration
- `TCB_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin policy with the `ptr` register.
  - Undefined: fixed priority, lowest index first, and no `ptr` register.
- Hold and response routing are identical in both builds.

## Structure
- `tcb_pkg` holds:
  - the select-width localparam rule `SW = $clog2(PN)`;
  - the one-hot-to-index function shared with the decoder.
- Sub-module `tcb_arb_pick`:
  - Combinational rotating priority encoder.
  - Inputs: request vector, start index.
  - Output: one-hot grant.
  - Fixed priority is `tcb_arb_pick` with start index constant 0.

## Test plan
- Reset, all idle:
  - Stimulus: hold `rst = 1` for 3 cycles with all `vld = 0`.
  - Required: `m.vld = 0` and all `s[i].rdy = 0` and `s[i].err = 0`.
  - Required, RR build: port 0 is granted first after release.
- Simultaneous read, PN=2:
  - Stimulus: `s[0]` reads `adr=0x10` and `s[1]` reads `adr=0x20` in the same cycle, `m.rdy = 1`.
  - Fixed build: `0x10` issued first, then `0x20`.
  - RR build: alternation continues over 4 cycles (0,1,0,1).
  - Required: `rdt` arrives 1 cycle after each transfer.
- Stall hold:
  - Stimulus: `s[1]` requests with `m.rdy = 0` for 3 cycles, then `s[0]` raises `vld`.
  - Required: grant stays on port 1 until `m.rdy = 1`; port 0 is served on the next cycle.
- Error routing:
  - Stimulus: `s[1]` write to `0x40`, and the subordinate returns `err = 1`.
  - Required: only `s[1].err = 1`, one cycle after the transfer; `s[0].err = 0`.
- Fairness, PN=4, RR build:
  - Stimulus: all ports request continuously for 8 transfers.
  - Required: grant order 0,1,2,3,0,1,2,3.
- Reset mid-stall:
  - Stimulus: assert `rst` during a held request.
  - Required: next cycle `hld = 0`, `rsp_vld = 0`, `ptr = PN-1`.
